// File: rtl/m65c02_mpc_pkg.sv
// m65c02_mpc_pkg: shared definitions for the M65C02A microprogram sequencer.
// Holds the 4-bit sequencer instruction encodings, the DJNZ alias used when
// the loop counter is compiled in, and the stack-pointer width helper.
package m65c02_mpc_pkg;

    localparam logic [3:0] pRTS  = 4'b0000;
    localparam logic [3:0] pBSR  = 4'b0001;
    localparam logic [3:0] pFTCH = 4'b0010;
    localparam logic [3:0] pBMW  = 4'b0011;
    localparam logic [3:0] pBRV0 = 4'b0100;
    localparam logic [3:0] pBRV1 = 4'b0101;
    localparam logic [3:0] pBRV2 = 4'b0110;
    localparam logic [3:0] pBRV3 = 4'b0111;
    localparam logic [3:0] pBTH0 = 4'b1000;
    localparam logic [3:0] pBTH1 = 4'b1001;
    localparam logic [3:0] pBTH2 = 4'b1010;
    localparam logic [3:0] pBTH3 = 4'b1011;
    localparam logic [3:0] pBTL0 = 4'b1100;
    localparam logic [3:0] pBTL1 = 4'b1101;
    localparam logic [3:0] pBTL2 = 4'b1110;
    localparam logic [3:0] pBTL3 = 4'b1111;

    // With the loop counter present, 1011 decrements and branches while nonzero.
    localparam logic [3:0] pDJNZ = pBTH3;

    // SP must hold 0..depth inclusive, so it needs one more state than depth.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/m65c02_mpc_stack.sv
// m65c02_mpc_stack: return-address LIFO for the microprogram sequencer.
// Entry sp-1 is the top of stack. A push into a full stack drops the oldest
// entry (index 0) and sets the sticky overflow flag; a pop from an empty
// stack leaves SP at zero and sets the sticky underflow flag.
module m65c02_mpc_stack
    import m65c02_mpc_pkg::*;
#(
    parameter int pStkDepth  = 4,
    parameter int pAddrWidth = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy,
    input  logic                              push,
    input  logic                              pop,
    input  logic [pAddrWidth-1:0]             din,
    output logic [pAddrWidth-1:0]             tos,
    output logic [sp_width(pStkDepth)-1:0]    sp,
    output logic                              ovf,
    output logic                              unf
);

    localparam int SpW = sp_width(pStkDepth);

    logic [pAddrWidth-1:0] stk [pStkDepth];
    logic                  full;
    logic                  empty;
    logic [SpW-1:0]        sp_top;

    assign full   = (sp == SpW'(pStkDepth));
    assign empty  = (sp == '0);
    assign sp_top = sp - SpW'(1);

    // Present the top entry, or zero when nothing has been pushed.
    always_comb begin
        tos = '0;
        for (int i = 0; i < pStkDepth; i++) begin
            if (!empty && (SpW'(i) == sp_top)) begin
                tos = stk[i];
            end
        end
    end

    // Push/pop bookkeeping, advancing only on enabled microcycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < pStkDepth; i++) begin
                stk[i] <= '0;
            end
        end else if (rdy) begin
            if (push) begin
                if (full) begin
                    for (int i = 0; i < pStkDepth - 1; i++) begin
                        stk[i] <= stk[i+1];
                    end
                    stk[pStkDepth-1] <= din;
                    ovf              <= 1'b1;
                end else begin
                    for (int i = 0; i < pStkDepth; i++) begin
                        if (SpW'(i) == sp) begin
                            stk[i] <= din;
                        end
                    end
                    sp <= sp + SpW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    sp <= sp_top;
                end
            end
        end
    end

endmodule

// File: rtl/m65c02_mpc_v6.sv
// m65c02_mpc_v6: parametrised microprogram sequencer for the M65C02A core.
// Holds the PC, incrementer, next-address mux and reset stretcher, plus an
// optional loop counter compiled in when MPC_LOOP_CNT_EN is defined (1011
// then acts as DJNZ). Without the macro, Cnt reads zero and 1011 is BTH3.
module m65c02_mpc_v6
    import m65c02_mpc_pkg::*;
#(
    parameter int                  pAddrWidth = 10,
    parameter int                  pStkDepth  = 4,
    parameter int                  pMWWidth   = 3,
    parameter int                  pCntWidth  = 8,
    parameter logic [pAddrWidth-1:0] pRst_Addrs = '0
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Rdy,
    input  logic [3:0]                     I,
    input  logic [3:0]                     T,
    input  logic [pMWWidth-1:0]            MW,
    input  logic [pAddrWidth-1:0]          BA,
    input  logic                           CntLd,
    input  logic [pCntWidth-1:0]           CntIn,
    output logic [1:0]                     Via,
    output logic [pAddrWidth-1:0]          MA,
    output logic [sp_width(pStkDepth)-1:0] SP,
    output logic                           StkOvf,
    output logic                           StkUnf,
    output logic [pCntWidth-1:0]           Cnt
);

    logic                  rst_d;
    logic                  mpc_rst;
    logic [pAddrWidth-1:0] pc;
    logic [pAddrWidth-1:0] next;
    logic [pAddrWidth-1:0] pc_in;
    logic [pAddrWidth-1:0] tos;
    logic                  push;
    logic                  pop;
    logic                  djnz_taken;

    assign mpc_rst = Rst | rst_d;
    assign next    = pc + pAddrWidth'(1);
    assign Via     = (I[3:2] == 2'b01) ? I[1:0] : 2'b00;
    assign MA      = mpc_rst ? pRst_Addrs : pc_in;
    assign push    = (I == pBSR) && !mpc_rst;
    assign pop     = (I == pRTS) && !mpc_rst;

    // Stretch reset by one clock so the PC settles before the first fetch.
    always_ff @(posedge Clk) begin
        rst_d <= Rst;
    end

`ifdef MPC_LOOP_CNT_EN
    logic [pCntWidth-1:0] cnt;

    assign Cnt        = cnt;
    assign djnz_taken = (cnt != '0);

    // Loop counter: a load wins over the DJNZ decrement.
    always_ff @(posedge Clk) begin
        if (mpc_rst) begin
            cnt <= '0;
        end else if (Rdy) begin
            if (CntLd) begin
                cnt <= CntIn;
            end else if ((I == pDJNZ) && djnz_taken) begin
                cnt <= cnt - pCntWidth'(1);
            end
        end
    end
`else
    logic unused_cnt;

    assign Cnt        = '0;
    assign djnz_taken = T[3];
    assign unused_cnt = ^{CntLd, CntIn};
`endif

    // Next-address selection from the sequencer instruction.
    always_comb begin
        pc_in = next;
        case (I)
            pRTS:  pc_in = tos;
            pBSR:  pc_in = BA;
            pFTCH: pc_in = next;
            pBMW:  pc_in = {BA[pAddrWidth-1:pMWWidth], MW};
            pBRV0, pBRV1, pBRV2, pBRV3: pc_in = BA;
            pBTH0: pc_in = T[0] ? BA : next;
            pBTH1: pc_in = T[1] ? BA : next;
            pBTH2: pc_in = T[2] ? BA : next;
            pBTH3: pc_in = djnz_taken ? BA : next;
            pBTL0: pc_in = T[0] ? next : BA;
            pBTL1: pc_in = T[1] ? next : BA;
            pBTL2: pc_in = T[2] ? next : BA;
            pBTL3: pc_in = T[3] ? next : BA;
            default: pc_in = next;
        endcase
    end

    // Program counter advances on each enabled microcycle.
    always_ff @(posedge Clk) begin
        if (mpc_rst) begin
            pc <= pRst_Addrs;
        end else if (Rdy) begin
            pc <= pc_in;
        end
    end

    m65c02_mpc_stack #(
        .pStkDepth  (pStkDepth),
        .pAddrWidth (pAddrWidth)
    ) u_stack (
        .clk  (Clk),
        .rst  (mpc_rst),
        .rdy  (Rdy),
        .push (push),
        .pop  (pop),
        .din  (next),
        .tos  (tos),
        .sp   (SP),
        .ovf  (StkOvf),
        .unf  (StkUnf)
    );

endmodule

// File: tb/tb_m65c02_mpc_v6.sv
// tb_m65c02_mpc_v6: directed self-checking bench for m65c02_mpc_v6 with
// default parameters (10-bit address, depth 4, 3-bit MW, 8-bit counter).
module tb_m65c02_mpc_v6;
    import m65c02_mpc_pkg::*;

    logic       Clk;
    logic       Rst;
    logic       Rdy;
    logic [3:0] I;
    logic [3:0] T;
    logic [2:0] MW;
    logic [9:0] BA;
    logic       CntLd;
    logic [7:0] CntIn;
    logic [1:0] Via;
    logic [9:0] MA;
    logic [2:0] SP;
    logic       StkOvf;
    logic       StkUnf;
    logic [7:0] Cnt;

    int tests;
    int failed;

    m65c02_mpc_v6 dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Rdy    (Rdy),
        .I      (I),
        .T      (T),
        .MW     (MW),
        .BA     (BA),
        .CntLd  (CntLd),
        .CntIn  (CntIn),
        .Via    (Via),
        .MA     (MA),
        .SP     (SP),
        .StkOvf (StkOvf),
        .StkUnf (StkUnf),
        .Cnt    (Cnt)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [3:0] ins, input logic [3:0] tst, input logic [9:0] ba);
        I  = ins;
        T  = tst;
        BA = ba;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Directed sequence of sequencer operations.
    initial begin
        logic [9:0] ovf_ba  [5];
        logic [9:0] ovf_ret [4];
        tests  = 0;
        failed = 0;
        Rst    = 1'b1;
        Rdy    = 1'b1;
        I      = pFTCH;
        T      = 4'h0;
        MW     = 3'd0;
        BA     = 10'h000;
        CntLd  = 1'b0;
        CntIn  = 8'h00;
        #1;
        chk("rst_ma0", MA, 10'h000);
        tick();
        chk("rst_ma1", MA, 10'h000);
        chk("rst_sp", SP, 3'd0);
        chk("rst_ovf", StkOvf, 1'b0);
        chk("rst_unf", StkUnf, 1'b0);
        chk("rst_cnt", Cnt, 8'h00);
        tick();
        chk("rst_ma2", MA, 10'h000);
        Rst = 1'b0;
        #1;
        chk("rst_stretch_ma", MA, 10'h000);
        tick();
        chk("ftch_ma1", MA, 10'h001);
        tick();
        chk("ftch_ma2", MA, 10'h002);
        tick();
        chk("ftch_ma3", MA, 10'h003);

        // Nested calls from 0x010/0x100/0x200/0x300, then unwind.
        drv(pBRV0, 4'h0, 10'h010);
        chk("brv0_ma", MA, 10'h010);
        chk("brv0_via", Via, 2'b00);
        tick();
        drv(pBSR, 4'h0, 10'h100);
        chk("bsr1_ma", MA, 10'h100);
        tick();
        chk("bsr1_sp", SP, 3'd1);
        drv(pBSR, 4'h0, 10'h200);
        tick();
        drv(pBSR, 4'h0, 10'h300);
        tick();
        drv(pBSR, 4'h0, 10'h340);
        tick();
        chk("bsr4_sp", SP, 3'd4);
        chk("bsr4_ovf", StkOvf, 1'b0);
        drv(pRTS, 4'h0, 10'h000);
        chk("rts1_ma", MA, 10'h301);
        tick();
        chk("rts1_sp", SP, 3'd3);
        chk("rts2_ma", MA, 10'h201);
        tick();
        chk("rts3_ma", MA, 10'h101);
        tick();
        chk("rts4_ma", MA, 10'h011);
        tick();
        chk("rts4_sp", SP, 3'd0);
        chk("rts4_ovf", StkOvf, 1'b0);
        chk("rts4_unf", StkUnf, 1'b0);

        // Five calls into a depth-4 stack: the oldest return (0x012) is lost.
        ovf_ba  = '{10'h020, 10'h030, 10'h040, 10'h050, 10'h060};
        ovf_ret = '{10'h051, 10'h041, 10'h031, 10'h021};
        for (int k = 0; k < 4; k++) begin
            drv(pBSR, 4'h0, ovf_ba[k]);
            tick();
        end
        chk("ovf_pre_sp", SP, 3'd4);
        chk("ovf_pre_flag", StkOvf, 1'b0);
        drv(pBSR, 4'h0, ovf_ba[4]);
        chk("ovf_bsr_ma", MA, 10'h060);
        tick();
        chk("ovf_sp", SP, 3'd4);
        chk("ovf_flag", StkOvf, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drv(pRTS, 4'h0, 10'h3AA);
            chk("ovf_rts_ma", MA, 32'(ovf_ret[k]));
            tick();
        end
        chk("unf_pre_sp", SP, 3'd0);
        chk("unf_pre_flag", StkUnf, 1'b0);
        chk("unf_empty_ma", MA, 10'h000);
        tick();
        chk("unf_flag", StkUnf, 1'b1);
        chk("unf_sp", SP, 3'd0);
        chk("unf_ovf_sticky", StkOvf, 1'b1);

        // Multi-way and test branches, via select, address wrap.
        MW = 3'd5;
        drv(pBMW, 4'h0, 10'h3F8);
        chk("bmw_ma", MA, 10'h3FD);
        tick();
        drv(pBTL2, 4'b0100, 10'h0AA);
        chk("btl2_t1_ma", MA, 10'h3FE);
        drv(pBTL2, 4'b1011, 10'h0AA);
        chk("btl2_t0_ma", MA, 10'h0AA);
        drv(pBTH0, 4'b1110, 10'h0AA);
        chk("bth0_t0_ma", MA, 10'h3FE);
        drv(pBTH0, 4'b0001, 10'h0AA);
        chk("bth0_t1_ma", MA, 10'h0AA);
        drv(pBTL2, 4'b0100, 10'h0AA);
        tick();
        drv(pBRV2, 4'h0, 10'h3FF);
        chk("brv2_via", Via, 2'b10);
        chk("brv2_ma", MA, 10'h3FF);
        tick();
        drv(pFTCH, 4'h0, 10'h000);
        chk("wrap_ma", MA, 10'h000);
        chk("ftch_via", Via, 2'b00);

        // Rdy low: nothing moves, MA still follows the inputs.
        Rdy = 1'b0;
        drv(pBSR, 4'h0, 10'h111);
        chk("hold_bsr_ma", MA, 10'h111);
        tick();
        tick();
        tick();
        chk("hold_sp", SP, 3'd0);
        chk("hold_ovf", StkOvf, 1'b1);
        chk("hold_unf", StkUnf, 1'b1);
        chk("hold_cnt", Cnt, 8'h00);
        drv(pFTCH, 4'h0, 10'h000);
        chk("hold_pc_ma", MA, 10'h000);
        Rdy = 1'b1;

`ifdef MPC_LOOP_CNT_EN
        CntLd = 1'b1;
        CntIn = 8'd3;
        tick();
        chk("cnt_load", Cnt, 8'd3);
        CntLd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(pDJNZ, 4'h0, 10'h050);
            chk("djnz_br_ma", MA, 10'h050);
            tick();
            chk("djnz_cnt", Cnt, 32'(2 - k));
        end
        drv(pDJNZ, 4'b1000, 10'h050);
        chk("djnz_fall_ma", MA, 10'h051);
        tick();
        chk("djnz_zero_cnt", Cnt, 8'd0);
        CntLd = 1'b1;
        CntIn = 8'd7;
        drv(pDJNZ, 4'h0, 10'h050);
        chk("djnz_ld_ma", MA, 10'h052);
        tick();
        chk("djnz_ld_cnt", Cnt, 8'd7);
        CntLd = 1'b0;
`else
        CntLd = 1'b1;
        CntIn = 8'd3;
        tick();
        chk("nocnt_ld", Cnt, 8'd0);
        CntLd = 1'b0;
        drv(pBTH3, 4'b1000, 10'h050);
        chk("bth3_t1_ma", MA, 10'h050);
        drv(pBTH3, 4'b0111, 10'h050);
        chk("bth3_t0_ma", MA, 10'h001);
        tick();
`endif

        // Reset mid-sequence overrides a call and clears all state.
        Rst = 1'b1;
        drv(pBSR, 4'h0, 10'h222);
        chk("midrst_ma", MA, 10'h000);
        tick();
        chk("midrst_sp", SP, 3'd0);
        chk("midrst_ovf", StkOvf, 1'b0);
        chk("midrst_unf", StkUnf, 1'b0);
        chk("midrst_cnt", Cnt, 8'd0);
        Rst = 1'b0;
        drv(pFTCH, 4'h0, 10'h000);
        chk("midrst_stretch_ma", MA, 10'h000);
        tick();
        chk("midrst_restart_ma", MA, 10'h001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
